jk_drive: RTL and testbench

//   Driver/checker that sits on the input side of a JK flip-flop. Accepts a stream of

---
 rtl/jk_drive.sv | 141 ++++++++++++++
 tb/tb_jk_drive.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_drive.sv
// jk_drive: feeds a JK flip-flop from a buffered stream of target Q bits.
// A small FIFO absorbs the valid/ready stream, one bit is popped per clock
// and turned into a registered J/K excitation, and an internal mirror of the
// flop is compared against the returned Q to count mismatches.
module jk_drive #(
  parameter int         DEPTH  = 4,
  parameter bit         POLICY = 1'b0,
  parameter int         CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_target,
  output logic             o_ready,
  output logic             o_j,
  output logic             o_k,
  input  logic             i_q,
  output logic             o_busy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t          state_q, state_d;
  logic            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            r_exp_q;
  logic            j_d, k_d;
  logic            push, pop, head, q_nx;

  // Flop characteristic equation: 00 hold, 01 reset, 10 set, 11 toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   jk_next = q;
      2'b01:   jk_next = 1'b0;
      2'b10:   jk_next = 1'b1;
      default: jk_next = ~q;
    endcase
  endfunction

  assign o_ready = (state_q == ST_RUN) && (count_q != FULL_CNT);
  assign push    = i_valid & o_ready;
  assign pop     = (state_q == ST_RUN) && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  // Value the flop will hold right after the coming edge; the popped bit
  // is compared against this, not against the current Q.
  assign q_nx    = jk_next(r_exp_q, o_j, o_k);
  assign o_busy  = (state_q != ST_RUN) | (count_q != '0) | o_j | o_k;

  // Next-state and next excitation: hold (00) unless a bit is being popped.
  always_comb begin
    state_d = state_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    case (state_q)
      ST_INIT:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_RUN;
      ST_RUN: begin
        if (pop && (head != q_nx)) begin
          if (POLICY) begin
            j_d = 1'b1;
            k_d = 1'b1;
          end else begin
            j_d = head;
            k_d = ~head;
          end
        end
      end
      default:   state_d = ST_INIT;
    endcase
  end

  // State register and J/K outputs; reset drives the clear excitation 0/1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      o_j     <= 1'b0;
      o_k     <= 1'b1;
    end else begin
      state_q <= state_d;
      o_j     <= j_d;
      o_k     <= k_d;
    end
  end

  // FIFO storage: plain memory, no reset needed since occupancy gates reads.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_target;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Internal mirror of the driven flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exp_q <= 1'b0;
    end else begin
      r_exp_q <= q_nx;
    end
  end

  // Mismatch detection: skipped in INIT because the flop is not yet cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else if ((state_q != ST_INIT) && (i_q != r_exp_q)) begin
      o_err <= 1'b1;
      if (o_err_cnt != '1) begin
        o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_drive.sv
// Bench for jk_drive: two instances (set/reset policy with 8-bit counter,
// toggle policy with 2-bit counter), each driving its own emulated JK flop.
// A stream-level model predicts every output each cycle; directed sections
// pin the model with hand-computed values.
module tb_jk_drive;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_target = 1'b0;
  logic       fault = 1'b0;
  logic       rdy [2];
  logic       oj [2];
  logic       okk [2];
  logic       busy [2];
  logic       err [2];
  logic       iq [2];
  logic       flop_q [2];
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jk_drive #(.DEPTH(4), .POLICY(1'b0), .CNT_W(8)) u0 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_target(i_target),
    .o_ready(rdy[0]), .o_j(oj[0]), .o_k(okk[0]), .i_q(iq[0]),
    .o_busy(busy[0]), .o_err(err[0]), .o_err_cnt(cnt0)
  );

  jk_drive #(.DEPTH(4), .POLICY(1'b1), .CNT_W(2)) u1 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_target(i_target),
    .o_ready(rdy[1]), .o_j(oj[1]), .o_k(okk[1]), .i_q(iq[1]),
    .o_busy(busy[1]), .o_err(err[1]), .o_err_cnt(cnt1)
  );

  // Emulated flops (environment, not the reference model).
  function automatic logic jkf(input logic q, input logic j, input logic k);
    if (j && k) return ~q;
    if (j) return 1'b1;
    if (k) return 1'b0;
    return q;
  endfunction

  always @(posedge clk) begin
    flop_q[0] <= jkf(flop_q[0], oj[0], okk[0]);
    flop_q[1] <= jkf(flop_q[1], oj[1], okk[1]);
  end

  assign iq[0] = fault ? 1'b0 : flop_q[0];
  assign iq[1] = fault ? 1'b0 : flop_q[1];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stream-level reference model ----------------
  // phase counts cycles since reset (0,1, then 2 = streaming). The flop is
  // expected to hold the last target that was popped one edge earlier.
  bit          m_live = 1'b0;
  int unsigned m_phase [2];
  bit          mq [2][$];
  bit          m_j [2], m_k [2], m_exp [2], m_pop [2], m_last [2], m_err [2];
  int unsigned m_cnt [2];
  bit          nf, t, m_rdy, m_dopop;

  function automatic int unsigned cmax(input int u);
    return (u == 0) ? 255 : 3;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (i_rst) begin
        m_phase[u] = 0;
        mq[u].delete();
        m_j[u] = 1'b0;
        m_k[u] = 1'b1;
        m_pop[u] = 1'b0;
        m_err[u] = 1'b0;
        m_cnt[u] = 0;
      end else begin
        if (m_phase[u] >= 1 && iq[u] != m_exp[u]) begin
          m_err[u] = 1'b1;
          if (m_cnt[u] < cmax(u)) m_cnt[u]++;
        end
        nf = (m_phase[u] == 0) ? 1'b0 : (m_pop[u] ? m_last[u] : m_exp[u]);
        m_rdy = (m_phase[u] == 2) && (mq[u].size() < 4);
        m_dopop = (m_phase[u] == 2) && (mq[u].size() > 0);
        m_pop[u] = m_dopop;
        m_j[u] = 1'b0;
        m_k[u] = 1'b0;
        if (m_dopop) begin
          t = mq[u].pop_front();
          m_last[u] = t;
          if (t != nf) begin
            m_j[u] = (u == 1) ? 1'b1 : t;
            m_k[u] = (u == 1) ? 1'b1 : ~t;
          end
        end
        if (i_valid && m_rdy) mq[u].push_back(i_target);
        m_exp[u] = nf;
        if (m_phase[u] < 2) m_phase[u]++;
      end
    end
    if (i_rst) m_live = 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_live) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d ready", u), int'(rdy[u]),
            int'((m_phase[u] == 2) && (mq[u].size() < 4)));
        chk($sformatf("u%0d j", u), int'(oj[u]), int'(m_j[u]));
        chk($sformatf("u%0d k", u), int'(okk[u]), int'(m_k[u]));
        chk($sformatf("u%0d busy", u), int'(busy[u]),
            int'((m_phase[u] != 2) || (mq[u].size() > 0) || m_j[u] || m_k[u]));
        chk($sformatf("u%0d err", u), int'(err[u]), int'(m_err[u]));
        chk($sformatf("u%0d cnt", u), (u == 0) ? int'(cnt0) : int'(cnt1), int'(m_cnt[u]));
        if (m_phase[u] >= 1)
          chk($sformatf("u%0d flopq", u), int'(flop_q[u]), int'(m_exp[u]));
      end
    end
  end

  // ---------------- directed and random stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    i_rst = 1'b1;
    i_valid = 1'b0;
    cyc();
    i_rst = 1'b0;
    cyc();
    cyc();
  endtask

  bit       s_bits [4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit [1:0] jk_p0 [4]    = '{2'b10, 2'b00, 2'b01, 2'b10};
  bit [1:0] jk_p1 [4]    = '{2'b11, 2'b00, 2'b11, 2'b11};
  bit       q_seq [4]    = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit       f_bits [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    flop_q[0] = 1'b1;
    flop_q[1] = 1'b1;

    // T1: reset then idle.
    i_rst = 1'b1;
    cyc();
    chk("t1 jk after reset", {oj[0], okk[0]}, 2'b01);
    chk("t1 ready after reset", int'(rdy[0]), 0);
    chk("t1 busy after reset", int'(busy[0]), 1);
    chk("t1 cnt after reset", int'(cnt0), 0);
    i_rst = 1'b0;
    cyc();
    chk("t1 jk settle", {oj[0], okk[0]}, 2'b00);
    chk("t1 ready settle", int'(rdy[0]), 0);
    chk("t1 flop cleared", int'(flop_q[0]), 0);
    cyc();
    chk("t1 ready run", int'(rdy[0]), 1);
    chk("t1 err idle", int'(err[0]), 0);
    cyc();

    // T2/T3: stream 1,1,0,1 back-to-back on both policies.
    for (int i = 0; i < 6; i++) begin
      i_valid = (i < 4);
      i_target = (i < 4) ? s_bits[i] : 1'b0;
      cyc();
      if (i >= 1 && i <= 4) begin
        chk($sformatf("t2 jk%0d", i - 1), {oj[0], okk[0]}, jk_p0[i - 1]);
        chk($sformatf("t3 jk%0d", i - 1), {oj[1], okk[1]}, jk_p1[i - 1]);
      end
      if (i >= 2) begin
        chk($sformatf("t2 q%0d", i - 2), int'(flop_q[0]), int'(q_seq[i - 2]));
        chk($sformatf("t3 q%0d", i - 2), int'(flop_q[1]), int'(q_seq[i - 2]));
      end
    end
    i_valid = 1'b0;
    cyc();
    chk("t2 cnt", int'(cnt0), 0);
    chk("t3 cnt", int'(cnt1), 0);

    // T4: randomized traffic with sporadic resets.
    for (int i = 0; i < 600; i++) begin
      i_rst = ($urandom_range(0, 99) == 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_target = 1'($urandom);
      cyc();
    end
    i_rst = 1'b0;
    i_valid = 1'b0;

    // T5: Q stuck at 0 while 1,0,1 is streamed (trailing 0 parks Q low).
    reset_seq();
    cyc();
    fault = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1;
      i_target = f_bits[i];
      cyc();
    end
    i_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("t5 err0", int'(err[0]), 1);
    chk("t5 cnt0", int'(cnt0), 2);
    chk("t5 cnt1", int'(cnt1), 2);
    i_valid = 1'b1;
    i_target = 1'b1;
    cyc();
    i_valid = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    chk("t5 cnt1 saturated", int'(cnt1), 3);
    chk("t5 cnt0 long", int'(cnt0), 12);
    chk("t5 err1", int'(err[1]), 1);
    fault = 1'b0;
    cyc();

    // T6: reset while a stream is in progress.
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_target = 1'(i);
      cyc();
    end
    i_rst = 1'b1;
    cyc();
    chk("t6 jk reset", {oj[0], okk[0]}, 2'b01);
    chk("t6 err cleared", int'(err[0]), 0);
    i_rst = 1'b0;
    i_valid = 1'b0;
    cyc();
    chk("t6 flop cleared", int'(flop_q[0]), 0);
    cyc();
    chk("t6 ready", int'(rdy[0]), 1);
    chk("t6 busy idle", int'(busy[0]), 0);
    i_valid = 1'b1;
    i_target = 1'b1;
    cyc();
    i_valid = 1'b0;
    cyc();
    chk("t6 jk u0", {oj[0], okk[0]}, 2'b10);
    chk("t6 jk u1", {oj[1], okk[1]}, 2'b11);
    cyc();
    chk("t6 q u0", int'(flop_q[0]), 1);
    chk("t6 q u1", int'(flop_q[1]), 1);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
